// File: rtl/fifo_burst_arbiter.sv
// fifo_burst_arbiter: round-robin burst scheduler draining channel FIFOs into a DDR write command/data port
//
// Ports:
//   rclk, rrst_n   DDR user clock, asynchronous active-low reset
//   ch_burst_rdy   per-channel "FIFO holds at least one burst" level
//   ch_rempty      per-channel fall-through FIFO empty flags
//   ch_rdata       per-channel FIFO read data, channel c at [c*DSIZE +: DSIZE]
//   ch_rinc        one-hot-or-zero FIFO pop strobes
//   ch_addr_rst    per-channel pulse returning the frame address to its base
//   cmd_*          write command (valid/ready, start word address, channel)
//   wr_*           write data (valid/ready, data)
//   busy           high whenever a burst is in progress
module fifo_burst_arbiter #(
    parameter int NCH         = 2,
    parameter int DSIZE       = 16,
    parameter int AW          = 28,
    parameter int BLEN        = 64,
    parameter int CH_STRIDE   = 2**22,
    parameter int FRAME_WORDS = 1280*720
) (
    input  logic                     rclk,
    input  logic                     rrst_n,
    input  logic [NCH-1:0]           ch_burst_rdy,
    input  logic [NCH-1:0]           ch_rempty,
    input  logic [NCH*DSIZE-1:0]     ch_rdata,
    output logic [NCH-1:0]           ch_rinc,
    input  logic [NCH-1:0]           ch_addr_rst,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic [AW-1:0]            cmd_addr,
    output logic [$clog2(NCH)-1:0]   cmd_ch,
    output logic                     wr_valid,
    input  logic                     wr_ready,
    output logic [DSIZE-1:0]         wr_data,
    output logic                     busy
);
    localparam int CW = $clog2(NCH);
    localparam int BW = $clog2(BLEN);

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   rr_ptr;
    logic [CW-1:0]   pick;
    logic [BW-1:0]   beat_cnt;
    logic [NCH-1:0]  pend;
    logic [AW-1:0]   addr [NCH];
    logic [AW-1:0]   bump [NCH];
    logic            beat;

    function automatic logic [AW-1:0] base(input int c);
        return AW'(c * CH_STRIDE);
    endfunction

    // Operand is always below 2*NCH, so one conditional subtract is a full modulo.
    function automatic logic [CW-1:0] wrap_idx(input int v);
        return CW'(v >= NCH ? v - NCH : v);
    endfunction

    // Scan downward so the request closest to rr_ptr is assigned last and wins.
    always_comb begin
        pick = rr_ptr;
        for (int i = NCH - 1; i >= 0; i--)
            if (ch_burst_rdy[wrap_idx(int'(rr_ptr) + i)])
                pick = wrap_idx(int'(rr_ptr) + i);
    end

    always_comb
        for (int c = 0; c < NCH; c++)
            bump[c] = (addr[c] + AW'(BLEN) == base(c) + AW'(FRAME_WORDS)) ? base(c) : addr[c] + AW'(BLEN);

    always_comb begin
        wr_valid = 1'b0;
        wr_data  = '0;
        ch_rinc  = '0;
        if (state == DATA) begin
            wr_valid = !ch_rempty[cmd_ch];
            for (int c = 0; c < NCH; c++)
                if (CW'(c) == cmd_ch)
                    wr_data = ch_rdata[c*DSIZE +: DSIZE];
            ch_rinc[cmd_ch] = wr_valid & wr_ready;
        end
    end

    assign beat = wr_valid & wr_ready;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            cmd_valid <= 1'b0;
            cmd_addr  <= '0;
            cmd_ch    <= '0;
            beat_cnt  <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|ch_burst_rdy) begin
                    cmd_ch    <= pick;
                    // A frame-start pulse on the winner this cycle must already steer this burst.
                    cmd_addr  <= ch_addr_rst[pick] ? base(int'(pick)) : addr[pick];
                    cmd_valid <= 1'b1;
                    busy      <= 1'b1;
                    state     <= CMD;
                end
                CMD: if (cmd_ready) begin
                    cmd_valid <= 1'b0;
                    beat_cnt  <= '0;
                    state     <= DATA;
                end
                DATA: if (beat) begin
                    beat_cnt <= beat_cnt + 1'b1;
                    if (beat_cnt == BW'(BLEN - 1))
                        state <= DONE;
                end
                DONE: begin
                    rr_ptr <= wrap_idx(int'(cmd_ch) + 1);
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A frame-start request on the channel being serviced is deferred to DONE so the
    // in-flight burst keeps its address and the post-burst increment does not overwrite it.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            pend <= '0;
            for (int c = 0; c < NCH; c++)
                addr[c] <= base(c);
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (state == DONE && CW'(c) == cmd_ch) begin
                    addr[c] <= (pend[c] || ch_addr_rst[c]) ? base(c) : bump[c];
                    pend[c] <= 1'b0;
                end else if (ch_addr_rst[c]) begin
                    if (state == IDLE || CW'(c) != cmd_ch)
                        addr[c] <= base(c);
                    else
                        pend[c] <= 1'b1;
                end
            end
        end
    end
endmodule
